// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor: ChaCha keystream engine that XORs each 512-bit block onto a
// valid/ready stream and auto-increments the 32-bit block counter.
// Optional macro CHACHA_POLYKEY_EN: after each init, one internal counter-0 block
// derives the Poly1305 one-time key (poly_key / poly_key_valid).
module chacha_stream_xor #(
  parameter int unsigned ROUNDS       = 20,
  parameter int unsigned UNROLL       = 1,
  parameter logic [31:0] CTR_INIT_DEF = 32'd1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic         ctr_load,
  input  logic [31:0]  ctr_in,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [511:0] s_data,
  input  logic [6:0]   s_bytes,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [511:0] m_data,
  output logic [6:0]   m_bytes,
  output logic [31:0]  m_ctr,
  output logic         ctr_wrap,
  output logic         keyed
`ifdef CHACHA_POLYKEY_EN
  ,
  output logic [255:0] poly_key,
  output logic         poly_key_valid
`endif
);

  localparam int unsigned N_STEPS = ROUNDS / (2 * UNROLL);
  localparam int unsigned SW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READY, S_ROUND, S_FINAL, S_OUT} state_t;
  typedef logic [15:0][31:0] blk_t;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                      input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // One column round followed by one diagonal round.
  function automatic blk_t dround(input blk_t x_i);
    blk_t x;
    x = x_i;
    for (int i = 0; i < 4; i++)
      {x[i], x[4+i], x[8+i], x[12+i]} = qr(x[i], x[4+i], x[8+i], x[12+i]);
    for (int i = 0; i < 4; i++)
      {x[i], x[4+((i+1)%4)], x[8+((i+2)%4)], x[12+((i+3)%4)]} =
        qr(x[i], x[4+((i+1)%4)], x[8+((i+2)%4)], x[12+((i+3)%4)]);
    return x;
  endfunction

  // Constants, key, counter, nonce; byte streams packed into little-endian words.
  function automatic blk_t init_state(input logic [255:0] k, input logic [95:0] n,
                                      input logic [31:0] c);
    blk_t s;
    s[0] = 32'h6170_7865; s[1] = 32'h3320_646e;
    s[2] = 32'h7962_2d32; s[3] = 32'h6b20_6574;
    for (int j = 0; j < 8; j++) s[4+j] = bswap32(k[255-32*j -: 32]);
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13+j] = bswap32(n[95-32*j -: 32]);
    return s;
  endfunction

  state_t r_state, w_state_nxt, w_init_st, w_fin_st;

  logic [255:0] r_key;
  logic [95:0]  r_nonce;
  logic [31:0]  r_ctr;
  logic [511:0] r_data;
  logic [6:0]   r_nbytes;
  blk_t         r_x;
  logic [SW-1:0] r_step;
  logic         r_fin;
  logic         r_s_ready, r_m_valid, r_ctr_wrap, r_keyed;
  logic [511:0] r_m_data;
  logic [6:0]   r_m_bytes;
  logic [31:0]  r_m_ctr;

  logic         w_hs_in, w_hs_out, w_last, w_wrap_nxt;
  logic         w_ld_blk, w_rnd, w_add, w_emit, w_adv;
  logic [6:0]   w_nbytes;
  logic [31:0]  w_ctr_word;
  blk_t         w_init, w_rounds, w_sum;
  logic [511:0] w_ks, w_mask, w_out;

`ifdef CHACHA_POLYKEY_EN
  logic         r_poly, r_pk_valid;
  logic [255:0] r_poly_key;
  assign w_init_st  = S_ROUND;
  assign w_fin_st   = r_poly ? S_READY : S_OUT;
  assign w_ctr_word = r_poly ? 32'd0 : r_ctr;
  assign poly_key       = r_poly_key;
  assign poly_key_valid = r_pk_valid;
`else
  assign w_init_st  = S_READY;
  assign w_fin_st   = S_OUT;
  assign w_ctr_word = r_ctr;
`endif

  assign w_hs_in  = s_valid & r_s_ready & ~init;
  assign w_hs_out = r_m_valid & m_ready;
  assign w_last   = (r_step == SW'(N_STEPS - 1));
  assign w_nbytes = ((s_bytes == 7'd0) || (s_bytes > 7'd64)) ? 7'd64 : s_bytes;
  assign w_init   = init_state(r_key, r_nonce, w_ctr_word);
  assign w_wrap_nxt = init ? 1'b0 : (r_ctr_wrap | (w_adv & (r_ctr == 32'hFFFF_FFFF)));

  // Round datapath: UNROLL double-rounds per clock, final add, serialise, XOR and mask.
  always_comb begin
    w_rounds = r_x;
    for (int u = 0; u < int'(UNROLL); u++) w_rounds = dround(w_rounds);
    w_sum  = '0;
    w_ks   = '0;
    w_mask = '0;
    for (int i = 0; i < 16; i++) begin
      w_sum[i]             = r_x[i] + w_init[i];
      w_ks[511-32*i -: 32] = bswap32(r_x[i]);
    end
    for (int i = 0; i < 64; i++) w_mask[511-8*i -: 8] = (7'(i) < r_nbytes) ? 8'hFF : 8'h00;
    w_out = (r_data ^ w_ks) & w_mask;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; init wins over any handshake and aborts a block in flight.
  always_comb begin
    w_state_nxt = r_state;
    if (init) begin
      w_state_nxt = w_init_st;
    end else begin
      case (r_state)
        S_READY: if (w_hs_in) w_state_nxt = S_ROUND;
        S_ROUND: if (w_last) w_state_nxt = S_FINAL;
        S_FINAL: if (r_fin) w_state_nxt = w_fin_st;
        S_OUT:   if (w_hs_out) w_state_nxt = S_READY;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Per-state datapath strobes; FINAL spends one cycle on the add and one on the output.
  always_comb begin
    w_ld_blk = 1'b0;
    w_rnd    = 1'b0;
    w_add    = 1'b0;
    w_emit   = 1'b0;
    w_adv    = 1'b0;
    if (!init) begin
      case (r_state)
        S_READY: w_ld_blk = w_hs_in;
        S_ROUND: w_rnd    = 1'b1;
        S_FINAL: begin
          w_add  = ~r_fin;
          w_emit = r_fin;
        end
        S_OUT:   w_adv    = w_hs_out;
        default: ;
      endcase
    end
  end

  // Key/counter registers, working state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key <= '0; r_nonce <= '0; r_ctr <= '0; r_data <= '0; r_nbytes <= '0;
      r_x <= '0; r_step <= '0; r_fin <= 1'b0;
      r_s_ready <= 1'b0; r_m_valid <= 1'b0; r_ctr_wrap <= 1'b0; r_keyed <= 1'b0;
      r_m_data <= '0; r_m_bytes <= '0; r_m_ctr <= '0;
`ifdef CHACHA_POLYKEY_EN
      r_poly <= 1'b0; r_pk_valid <= 1'b0; r_poly_key <= '0;
`endif
    end else begin
`ifdef CHACHA_POLYKEY_EN
      r_pk_valid <= 1'b0;
`endif
      if (init) begin
        r_key     <= key;
        r_nonce   <= nonce;
        r_ctr     <= ctr_load ? ctr_in : CTR_INIT_DEF;
        r_keyed   <= 1'b1;
        r_m_valid <= 1'b0;
`ifdef CHACHA_POLYKEY_EN
        r_poly <= 1'b1;
        r_x    <= init_state(key, nonce, 32'd0);
        r_step <= '0;
        r_fin  <= 1'b0;
`endif
      end
      if (w_ld_blk) begin
        r_data   <= s_data;
        r_nbytes <= w_nbytes;
        r_x      <= w_init;
        r_step   <= '0;
        r_fin    <= 1'b0;
      end
      if (w_rnd) begin
        r_x    <= w_rounds;
        r_step <= r_step + SW'(1);
      end
      if (w_add) begin
        r_x   <= w_sum;
        r_fin <= 1'b1;
      end
      if (w_emit) begin
`ifdef CHACHA_POLYKEY_EN
        if (r_poly) begin
          r_poly_key <= w_ks[511:256];
          r_pk_valid <= 1'b1;
          r_poly     <= 1'b0;
        end else begin
          r_m_data <= w_out; r_m_bytes <= r_nbytes; r_m_ctr <= r_ctr; r_m_valid <= 1'b1;
        end
`else
        r_m_data <= w_out; r_m_bytes <= r_nbytes; r_m_ctr <= r_ctr; r_m_valid <= 1'b1;
`endif
      end
      if (w_adv) begin
        r_m_valid <= 1'b0;
        r_ctr     <= r_ctr + 32'd1;
      end
      r_ctr_wrap <= w_wrap_nxt;
      r_s_ready  <= (w_state_nxt == S_READY) & ~w_wrap_nxt;
    end
  end

  assign s_ready  = r_s_ready;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_bytes  = r_m_bytes;
  assign m_ctr    = r_m_ctr;
  assign ctr_wrap = r_ctr_wrap;
  assign keyed    = r_keyed;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// tb_chacha_stream_xor: randomized self-checking bench for chacha_stream_xor
// against a word-array ChaCha reference model.
module tb_chacha_stream_xor;

  localparam int unsigned ROUNDS = 20;
  localparam int unsigned LAT    = ROUNDS / 2 + 2;

  logic         clk, reset_n, init, ctr_load, s_valid, s_ready, m_valid, m_ready;
  logic         ctr_wrap, keyed;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_in, m_ctr;
  logic [511:0] s_data, m_data;
  logic [6:0]   s_bytes, m_bytes;

  logic [255:0] cur_key;
  logic [95:0]  cur_nonce;
  logic [31:0]  exp_ctr;
  int           n_checks, n_fail;

  chacha_stream_xor #(.ROUNDS(ROUNDS), .UNROLL(1), .CTR_INIT_DEF(32'd1)) dut (
    .clk(clk), .reset_n(reset_n), .init(init), .key(key), .nonce(nonce),
    .ctr_load(ctr_load), .ctr_in(ctr_in), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_bytes(s_bytes), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_bytes(m_bytes), .m_ctr(m_ctr), .ctr_wrap(ctr_wrap), .keyed(keyed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference ChaCha block: build state from bytes, run rounds, add, XOR, mask.
  function automatic logic [511:0] model_block(input logic [255:0] k, input logic [95:0] nn,
                                               input logic [31:0] ctr, input logic [511:0] d,
                                               input int nb);
    logic [31:0] s [16];
    logic [31:0] w [16];
    logic [31:0] sum;
    logic [7:0]  ksb;
    logic [511:0] o;
    int unsigned q [8][4];
    int unsigned ia, ib, ic, id;
    q = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
          '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    for (int j = 0; j < 16; j++) s[j] = 32'd0;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 32; j++) s[4 + j/4] += 32'(k[255-8*j -: 8]) << (8 * (j % 4));
    s[12] = ctr;
    for (int j = 0; j < 12; j++) s[13 + j/4] += 32'(nn[95-8*j -: 8]) << (8 * (j % 4));
    w = s;
    for (int r = 0; r < int'(ROUNDS / 2); r++) begin
      for (int qi = 0; qi < 8; qi++) begin
        ia = q[qi][0]; ib = q[qi][1]; ic = q[qi][2]; id = q[qi][3];
        w[ia] = w[ia] + w[ib]; w[id] = rol(w[id] ^ w[ia], 16);
        w[ic] = w[ic] + w[id]; w[ib] = rol(w[ib] ^ w[ic], 12);
        w[ia] = w[ia] + w[ib]; w[id] = rol(w[id] ^ w[ia], 8);
        w[ic] = w[ic] + w[id]; w[ib] = rol(w[ib] ^ w[ic], 7);
      end
    end
    o = '0;
    for (int i = 0; i < 64; i++) begin
      sum = w[i/4] + s[i/4];
      ksb = 8'(sum >> (8 * (i % 4)));
      o[511-8*i -: 8] = (i < nb) ? (d[511-8*i -: 8] ^ ksb) : 8'h00;
    end
    return o;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int j = 0; j < 16; j++) v[511-32*j -: 32] = $urandom();
    return v;
  endfunction

  // Pulse init for one cycle; call at a falling edge.
  task automatic do_init(input logic [255:0] k, input logic [95:0] n, input logic ld,
                         input logic [31:0] cin);
    key = k; nonce = n; ctr_load = ld; ctr_in = cin; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    cur_key = k; cur_nonce = n;
    exp_ctr = ld ? cin : 32'd1;
  endtask

  // Send one block, check latency and result, optionally hold backpressure and ack.
  task automatic do_block(input logic [511:0] d, input logic [6:0] b, input int hold,
                          input bit ack, input string tag);
    logic [511:0] exp;
    int nb, n, lat;
    nb  = ((b == 7'd0) || (b > 7'd64)) ? 64 : int'(b);
    exp = model_block(cur_key, cur_nonce, exp_ctr, d, nb);
    @(negedge clk);
    s_data = d; s_bytes = b; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    check_eq({tag, "_s_ready"}, 512'(s_ready), 512'(1));
    @(negedge clk);
    s_valid = 1'b0;
    check_eq({tag, "_s_ready_drop"}, 512'(s_ready), 512'(0));
    lat = 0;
    while (!m_valid && lat < 40) begin @(negedge clk); lat++; end
    check_eq({tag, "_latency"}, 512'(lat), 512'(LAT));
    check_eq({tag, "_m_data"}, m_data, exp);
    check_eq({tag, "_m_ctr"}, 512'(m_ctr), 512'(exp_ctr));
    if (b != 7'd0 && b <= 7'd64) check_eq({tag, "_m_bytes"}, 512'(m_bytes), 512'(b));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 512'(m_valid), 512'(1));
      check_eq({tag, "_hold_data"}, m_data, exp);
      check_eq({tag, "_hold_ctr"}, 512'(m_ctr), 512'(exp_ctr));
      check_eq({tag, "_hold_s_ready"}, 512'(s_ready), 512'(0));
    end
    if (ack) begin
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check_eq({tag, "_valid_clear"}, 512'(m_valid), 512'(0));
      exp_ctr = exp_ctr + 32'd1;
    end
  endtask

  initial begin
    logic [255:0] rk;
    logic [95:0]  rn;
    logic [511:0] ff_data, tmp;
    bit seen;
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; init = 1'b0; ctr_load = 1'b0; ctr_in = '0; key = '0; nonce = '0;
    s_valid = 1'b0; s_data = '0; s_bytes = '0; m_ready = 1'b0;
    exp_ctr = '0; cur_key = '0; cur_nonce = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", 512'(s_ready), 512'(0));
    check_eq("rst_m_valid", 512'(m_valid), 512'(0));
    check_eq("rst_keyed", 512'(keyed), 512'(0));
    check_eq("rst_ctr_wrap", 512'(ctr_wrap), 512'(0));
    check_eq("rst_m_data", m_data, 512'(0));
    check_eq("rst_m_ctr", 512'(m_ctr), 512'(0));
    reset_n = 1'b1;

    // IDLE refuses input
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_s_ready", 512'(s_ready), 512'(0));
    check_eq("idle_m_valid", 512'(m_valid), 512'(0));
    s_valid = 1'b0;

    // RFC 8439 block with backpressure
    rk = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    do_init(rk, 96'h000000090000004a00000000, 1'b1, 32'd1);
    check_eq("init_keyed", 512'(keyed), 512'(1));
    check_eq("init_s_ready", 512'(s_ready), 512'(1));
    do_block('0, 7'd64, 0, 1'b0, "rfc");
    tmp = m_data;
    check_eq("rfc_ks_hi", 512'(tmp[511:384]), 512'(128'h10f1e7e4d13b5915500fdd1fa32071c4));
    check_eq("rfc_ctr", 512'(m_ctr), 512'(32'd1));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check_eq("bp_data", 512'(m_data), 512'(tmp));
      check_eq("bp_ctr", 512'(m_ctr), 512'(32'd1));
      check_eq("bp_s_ready", 512'(s_ready), 512'(0));
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_eq("bp_valid_clear", 512'(m_valid), 512'(0));
    exp_ctr = exp_ctr + 32'd1;

    // Random key, default counter, three streamed blocks
    for (int j = 0; j < 8; j++) rk[255-32*j -: 32] = $urandom();
    rn = {$urandom(), $urandom(), $urandom()};
    do_init(rk, rn, 1'b0, 32'hDEAD_BEEF);
    for (int blk = 0; blk < 3; blk++) begin
      do_block(rand512(), 7'd64, (blk == 1) ? 2 : 0, 1'b1, "stream");
    end
    check_eq("stream_next_ctr", 512'(exp_ctr), 512'(32'd4));

    // Partial blocks
    ff_data = '1;
    do_block(ff_data, 7'd5, 0, 1'b1, "part5");
    tmp = m_data;
    check_eq("part5_tail_zero", 512'(tmp[471:0]), 512'(0));
    do_block(rand512(), 7'($urandom_range(1, 63)), 0, 1'b1, "partrnd");
    do_block(rand512(), 7'd0, 0, 1'b1, "bytes0");
    do_block(rand512(), 7'd100, 0, 1'b1, "bytes100");

    // Counter wrap
    do_init(rk, rn, 1'b1, 32'hFFFF_FFFE);
    do_block(rand512(), 7'd64, 0, 1'b1, "wrap_a");
    do_block(rand512(), 7'd64, 0, 1'b1, "wrap_b");
    check_eq("wrap_flag", 512'(ctr_wrap), 512'(1));
    s_valid = 1'b1; s_data = rand512(); s_bytes = 7'd64;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("wrap_s_ready", 512'(s_ready), 512'(0));
    end
    check_eq("wrap_no_valid", 512'(m_valid), 512'(0));
    s_valid = 1'b0;
    @(negedge clk);
    do_init(rk, rn, 1'b1, 32'h10);
    check_eq("wrap_clr_flag", 512'(ctr_wrap), 512'(0));
    check_eq("wrap_clr_s_ready", 512'(s_ready), 512'(1));

    // Abort three cycles into ROUND
    do_init(rk, rn, 1'b1, 32'h100);
    s_data = rand512(); s_bytes = 7'd64; s_valid = 1'b1;
    check_eq("abort_s_ready", 512'(s_ready), 512'(1));
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    do_init(rk, rn, 1'b1, 32'h200);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check_eq("abort_no_valid", 512'(seen), 512'(0));
    do_block(rand512(), 7'd64, 0, 1'b1, "post_abort");

    // init and s_valid together: init wins
    key = rk; nonce = rn; ctr_load = 1'b1; ctr_in = 32'h300;
    init = 1'b1; s_valid = 1'b1; s_data = rand512(); s_bytes = 7'd64;
    @(negedge clk);
    init = 1'b0; s_valid = 1'b0; exp_ctr = 32'h300;
    seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check_eq("init_wins_no_valid", 512'(seen), 512'(0));
    check_eq("init_wins_s_ready", 512'(s_ready), 512'(1));
    do_block(rand512(), 7'd64, 0, 1'b1, "post_initwin");

    // Reset while in OUT
    do_block(rand512(), 7'd64, 0, 1'b0, "pre_reset");
    reset_n = 1'b0;
    #1;
    check_eq("rst_out_m_valid", 512'(m_valid), 512'(0));
    check_eq("rst_out_keyed", 512'(keyed), 512'(0));
    check_eq("rst_out_m_data", m_data, 512'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
